imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot/programming controller for the instruction ROM.
- Accepts a framed byte stream (typically from a UART receiver) and assembles little-endian 32-bit words.
- Drives the instruction memory's word write port, and holds the single-cycle core in reset while a load is in progress or has failed.
- Sits between the serial receiver, the instruction memory write port and the core reset tree.

Parameters:
- DEPTH, 256, instruction memory depth in words.
- ADDR_W, 8, word-index width; must equal clog2(DEPTH).
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles between bytes inside a frame before abort.
- HOLD_AT_RESET, 0, if 1 the core is held after reset until the first successful load.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- load_req  in  1  single-cycle pulse that starts a load frame.
- rx_valid  in  1  byte available.
- rx_data  in  8  byte value.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- mem_we  out  1  one-cycle word write strobe.
- mem_waddr  out  ADDR_W  word index being written.
- mem_wdata  out  32  assembled word.
- cpu_hold  out  1  core reset hold.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky error flag.
- words_loaded  out  16  words written in the current or last frame.

Behaviour:
- Reset values:
  - state IDLE.
  - rx_ready, mem_we, busy, done and error are 0.
  - mem_waddr and mem_wdata are 0; words_loaded is 0.
  - cpu_hold equals HOLD_AT_RESET.
  - Internal checksum, byte counter and timeout counter are cleared.
- Frame format: LEN_LO, LEN_HI (N = 16-bit word count), then 4*N data bytes (LSB first per word), then CHK. CHK is the 8-bit modulo-256 sum of all data bytes.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHK, FAIL.
- IDLE:
  - rx_ready=0.
  - load_req moves to LEN_LO; clears error, words_loaded and checksum; sets busy=1 and cpu_hold=1.
- LEN_LO / LEN_HI / DATA / CHK:
  - rx_ready=1 and busy=1.
  - Each accepted byte advances the byte counter.
- LEN_HI exit:
  - N > DEPTH goes to FAIL.
  - N == 0 goes to CHK.
  - Otherwise goes to DATA.
- DATA:
  - Byte k of a word goes into lane k.
  - When the 4th byte is accepted, mem_we=1 is asserted on the next cycle for exactly one cycle, with mem_waddr = word index (starting at 0) and the full word on mem_wdata. words_loaded increments in the same cycle.
  - After word N-1 is accepted, go to CHK.
  - Back-to-back bytes every cycle must be sustained; a byte accepted in the same cycle as mem_we is legal.
- CHK:
  - Received byte equal to the running sum: pulse done, drop busy and cpu_hold, return to IDLE.
  - Mismatch: go to FAIL.
- FAIL: one cycle; sets error=1, busy=0, keeps cpu_hold=1, then IDLE. Words already written are not rolled back.
- Timeout:
  - Counter resets on every accepted byte and on entry to LEN_LO.
  - Reaching TIMEOUT_CYCLES-1 in LEN_LO..CHK goes to FAIL.
- load_req while busy is ignored.
- load_req while error=1 starts a new frame.
- mem_waddr never wraps; N ≤ DEPTH guarantees index < DEPTH.
- rst mid-frame:
  - Returns to the reset state next cycle with no further writes; a pending mem_we is dropped.
  - cpu_hold goes to HOLD_AT_RESET.
- The instruction memory must add a synchronous write port (mem_we/mem_waddr/mem_wdata). Its combinational read port is unchanged.

Decomposition:
- Shared package imem_loader_pkg:
  - state enum loader_state_t.
  - Frame constants LEN_BYTES=2, CHK_BYTES=1 and BYTES_PER_WORD=4.
- One natural sub-module, imem_word_packer: byte-to-word shift/lane register with word_valid pulse and running checksum.
- The FSM, timeout counter and hold logic stay in imem_loader.

Test Plan:
- Normal load:
  - Stimulus: load_req, then bytes 02 00 | 13 00 00 00 | 6F 00 00 00 | 82, one per cycle.
  - Required: writes (0,0x00000013) and (1,0x0000006F); done pulses once; cpu_hold falls; words_loaded=2; error=0.
- Bad checksum:
  - Stimulus: same frame with CHK=0x83.
  - Required: both writes still occur; error=1; cpu_hold=1; no done pulse.
- Oversize length:
  - Stimulus: LEN=0x0101 (257) with DEPTH=256.
  - Required: FAIL right after LEN_HI; zero writes; error=1.
- Zero-length frame:
  - Stimulus: 00 00 00.
  - Required: done pulses; no writes; words_loaded=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; stop after 3 data bytes.
  - Required: error=1 after 16 idle cycles; no mem_we; a following load_req clears error and loads correctly.
- Reset mid-frame:
  - Stimulus: assert rst in the same cycle as the 4th data byte.
  - Required: no mem_we; state IDLE; busy=0; cpu_hold=HOLD_AT_RESET.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CHK,
    ST_FAIL
  } loader_state_t;

  localparam int unsigned LEN_BYTES      = 2;
  localparam int unsigned CHK_BYTES      = 1;
  localparam int unsigned BYTES_PER_WORD = 4;

  // States in which a frame is open and bytes are being accepted.
  function automatic logic is_active(loader_state_t s);
    return s inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHK};
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Assembles little-endian words from accepted data bytes, emits a one-cycle
// word_valid after the last lane, and keeps the modulo-256 byte checksum.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [7:0]  checksum
);

  localparam int unsigned LANE_W = $clog2(BYTES_PER_WORD);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic [7:0]        sum_q, sum_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q       <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      sum_q        <= '0;
    end else begin
      lane_q       <= lane_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      sum_q        <= sum_d;
    end
  end

  assign last_lane = (lane_q == LANE_W'(BYTES_PER_WORD - 1));

  always_comb begin
    lane_d       = lane_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    sum_d        = sum_q;
    if (clear) begin
      lane_d = '0;
      sum_d  = '0;
    end else if (byte_valid) begin
      shift_d[{lane_q, 3'b000} +: 8] = byte_data;
      sum_d  = sum_q + byte_data;
      lane_d = lane_q + 1'b1;
      if (last_lane) begin
        word_d       = shift_d;
        word_valid_d = 1'b1;
      end
    end
  end

  assign word_valid = word_valid_q;
  assign word_data  = word_q;
  assign checksum   = sum_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses LEN/DATA/CHK frames, writes words into instruction
// memory and holds the core in reset while a load is open or has failed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned HOLD_AT_RESET  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  loader_state_t     state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_q, words_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [TO_W-1:0]   timeout_q, timeout_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              hold_q, hold_d;

  logic        accept;
  logic        start;
  logic        last_lane;
  logic        word_valid;
  logic [31:0] word_data;
  logic [7:0]  checksum;

  assign accept = rx_valid && rx_ready;
  assign start  = (state_q == ST_IDLE) && load_req;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start),
    .byte_valid (accept && (state_q == ST_DATA)),
    .byte_data  (rx_data),
    .last_lane  (last_lane),
    .word_valid (word_valid),
    .word_data  (word_data),
    .checksum   (checksum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_lo_q  <= '0;
      len_q     <= '0;
      words_q   <= '0;
      waddr_q   <= '0;
      timeout_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      hold_q    <= (HOLD_AT_RESET != 0);
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      words_q   <= words_d;
      waddr_q   <= waddr_d;
      timeout_q <= timeout_d;
      done_q    <= done_d;
      error_q   <= error_d;
      hold_q    <= hold_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_lo_d  = len_lo_q;
    len_d     = len_q;
    words_d   = words_q;
    waddr_d   = waddr_q;
    timeout_d = accept ? '0 : timeout_q + 1'b1;
    done_d    = 1'b0;
    error_d   = error_q;
    hold_d    = hold_q;
    case (state_q)
      ST_IDLE: begin
        timeout_d = '0;
        if (load_req) begin
          state_d = ST_LEN_LO;
          error_d = 1'b0;
          words_d = '0;
          hold_d  = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          len_lo_d = rx_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_d = {rx_data, len_lo_q};
          if ({1'b0, len_d} > 17'(DEPTH))  state_d = ST_FAIL;
          else if (len_d == '0)            state_d = ST_CHK;
          else                             state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept && last_lane) begin
          waddr_d = words_q[ADDR_W-1:0];
          words_d = words_q + 16'd1;
          if (words_q == len_q - 16'd1) state_d = ST_CHK;
        end
      end
      ST_CHK: begin
        if (accept) begin
          if (rx_data == checksum) begin
            done_d  = 1'b1;
            hold_d  = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_FAIL: begin
        timeout_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A byte arriving on the last permitted cycle still counts as on time.
    if (is_active(state_q) && !accept && timeout_q == TO_W'(TIMEOUT_CYCLES - 1))
      state_d = ST_FAIL;
    if (state_d == ST_FAIL) error_d = 1'b1;
  end

  always_comb begin
    rx_ready     = is_active(state_q);
    busy         = is_active(state_q);
    mem_we       = word_valid;
    mem_waddr    = waddr_q;
    mem_wdata    = word_data;
    cpu_hold     = hold_q;
    done         = done_q;
    error        = error_q;
    words_loaded = words_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frame-level reference model predicts
// writes and end-of-frame status; a monitor checks every mem_we.
module tb_imem_loader;

  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned TMO    = 16;
  localparam int unsigned HOLD   = 1;

  logic              clk = 1'b0;
  logic              rst, load_req, rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready, mem_we, cpu_hold, busy, done, error;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic [15:0]       words_loaded;

  always #5 clk = ~clk;

  imem_loader #(
    .DEPTH          (DEPTH),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO),
    .HOLD_AT_RESET  (HOLD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_req     (load_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] fr[$];
  int checks = 0, passes = 0, wr_seen = 0, done_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (done) done_seen++;
    if (mem_we) begin
      wr_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("waddr", 32'(mem_waddr), 32'(e.addr));
        check("wdata", mem_wdata, e.data);
        check("words_at_we", 32'(words_loaded), 32'(e.addr) + 32'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit ld);
    int guard = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    load_req = ld;
    while (!rx_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (!rx_ready) check("rx_ready_wait", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic pulse_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Reference model works on the whole frame: length, word list, byte sum.
  task automatic run_frame(input int n_send, input int max_gap, input bit ld_mid);
    int         n, exp_writes, w0, d0, guard, tot;
    bit         ok;
    logic [7:0] sum;
    n = int'({fr[1], fr[0]});
    exp_writes = 0;
    sum = 8'h00;
    ok = 1'b0;
    w0 = wr_seen;
    d0 = done_seen;
    if (n <= int'(DEPTH)) begin
      for (int w = 0; w < n; w++) begin
        int b;
        b = 2 + 4 * w;
        if (b + 4 <= n_send) begin
          exp_q.push_back('{addr: ADDR_W'(w), data: {fr[b+3], fr[b+2], fr[b+1], fr[b]}});
          exp_writes++;
        end
      end
      for (int i = 2; i < 2 + 4 * n; i++) sum = sum + fr[i];
      ok = (n_send == fr.size()) && (fr[fr.size()-1] == sum);
    end
    pulse_load();
    for (int i = 0; i < n_send; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(fr[i], ld_mid && (i == 3));
    end
    tot = 0;
    if (n_send < fr.size() && n <= int'(DEPTH)) begin
      repeat (TMO - 2) @(negedge clk);
      tot = TMO - 2;
      check("no_early_timeout", 32'(busy), 32'd1);
    end
    guard = 0;
    while (busy && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    check("frame_ends", 32'(busy), 32'd0);
    if (tot != 0) begin
      tot += guard;
      check("timeout_window", 32'(tot >= int'(TMO) && tot <= int'(TMO) + 2), 32'd1);
    end
    repeat (3) @(negedge clk);
    check("write_count", 32'(wr_seen - w0), 32'(exp_writes));
    check("done_pulses", 32'(done_seen - d0), ok ? 32'd1 : 32'd0);
    check("error", 32'(error), ok ? 32'd0 : 32'd1);
    check("cpu_hold", 32'(cpu_hold), ok ? 32'd0 : 32'd1);
    check("words_loaded", 32'(words_loaded), 32'(exp_writes));
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic make_random_frame(input int n, input bit good);
    logic [7:0] sum;
    sum = 8'h00;
    fr.delete();
    fr.push_back(n[7:0]);
    fr.push_back(n[15:8]);
    for (int i = 0; i < 4 * n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      fr.push_back(b);
      sum = sum + b;
    end
    fr.push_back(good ? sum : sum + 8'd1);
  endtask

  initial begin
    int w0;
    rst = 1'b1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_words", 32'(words_loaded), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'(HOLD));

    fr = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    run_frame(fr.size(), 0, 1'b0);
    fr[10] = 8'h83;
    run_frame(fr.size(), 0, 1'b0);
    fr = {8'h01, 8'h01};
    run_frame(2, 0, 1'b0);
    fr = {8'h00, 8'h00, 8'h00};
    run_frame(3, 0, 1'b0);
    fr = {8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h82};
    run_frame(5, 0, 1'b0);
    run_frame(fr.size(), 1, 1'b0);

    // Reset lands in the same cycle as the 4th data byte.
    w0 = wr_seen;
    pulse_load();
    for (int i = 0; i < 5; i++) send_byte(fr[i], 1'b0);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = fr[5];
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    rx_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rstmid_writes", 32'(wr_seen - w0), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_rx_ready", 32'(rx_ready), 32'd0);
    check("rstmid_cpu_hold", 32'(cpu_hold), 32'(HOLD));
    check("rstmid_words", 32'(words_loaded), 32'd0);

    make_random_frame(int'(DEPTH), 1'b1);
    run_frame(fr.size(), 0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      make_random_frame(int'($urandom_range(1, 6)), $urandom_range(0, 3) != 0);
      run_frame(fr.size(), 2, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
